// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
//
// Sequences the byte stream from a UART receiver into checked register-write
// bursts. Frames are SYNC, ADDR, LEN, PAYLOAD[LEN], CHK. The payload is
// buffered and replayed as address-incrementing writes only when the 8-bit
// sum of ADDR..CHK is zero modulo 256.
//
// Optional feature macro: UART_FRAME_TIMEOUT_EN
//   defined   -> inter-byte timeout counter; abort with code 11 on expiry
//   undefined -> no counter; the block waits indefinitely for the next byte
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   rx_data      received byte, valid while rx_done is high
//   rx_done      one-cycle pulse per received byte
//   rx_err       receiver framing error (any high cycle counts)
//   wr_en        register write strobe
//   wr_addr      write address
//   wr_data      write data
//   frame_done   one-cycle pulse after a successful frame
//   frame_err    one-cycle pulse on frame abort
//   err_code     abort cause (00 UART, 01 LEN, 10 CHK, 11 TIMEOUT), held
//   busy         high whenever the controller is not idle
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
    parameter logic [7:0]  P_SYNC        = 8'hA5,
    parameter int          P_MAX_LEN     = 16,
    parameter logic [15:0] P_TIMEOUT_CNT = 16'd43300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rx_err,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int         IDX_W     = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(P_MAX_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CHK     = 3'd4;
    localparam logic [2:0] S_COMMIT  = 3'd5;

    localparam logic [1:0] ERR_UART    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    logic [2:0] state_q, state_d;
    logic [7:0] base_q, base_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] idx_q, idx_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       frame_done_q, frame_done_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0] err_code_q, err_code_d;
    logic       busy_q, busy_d;
    logic       pay_we;
    logic [7:0] chk_sum;
    logic       parse_state;

    logic [7:0] pay_mem_q [P_MAX_LEN];

    assign parse_state = (state_q == S_ADDR) || (state_q == S_LEN) ||
                         (state_q == S_PAYLOAD) || (state_q == S_CHK);
    assign chk_sum     = sum_q + rx_data;

`ifdef UART_FRAME_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        to_hit;
    assign to_hit = (to_cnt_q == P_TIMEOUT_CNT);
`endif

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        sum_d        = sum_q;
        idx_d        = idx_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        pay_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_done && (rx_data == P_SYNC)) state_d = S_ADDR;
            end

            // Replay one buffered byte per cycle; the first write was already
            // issued from CHK, so idx starts at 1 here.
            S_COMMIT: begin
                if (idx_q < len_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + idx_q;
                    wr_data_d = pay_mem_q[idx_q[IDX_W-1:0]];
                    idx_d     = idx_q + 8'd1;
                end else begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                // Receiver errors win over a byte completing in the same cycle.
                if (rx_err) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_UART;
                    state_d     = S_IDLE;
                end else if (rx_done) begin
                    case (state_q)
                        S_ADDR: begin
                            base_d  = rx_data;
                            sum_d   = rx_data;
                            state_d = S_LEN;
                        end
                        S_LEN: begin
                            len_d = rx_data;
                            sum_d = chk_sum;
                            idx_d = 8'd0;
                            if (rx_data > MAX_LEN_B) begin
                                frame_err_d = 1'b1;
                                err_code_d  = ERR_LEN;
                                state_d     = S_IDLE;
                            end else if (rx_data == 8'd0) begin
                                state_d = S_CHK;
                            end else begin
                                state_d = S_PAYLOAD;
                            end
                        end
                        S_PAYLOAD: begin
                            pay_we = 1'b1;
                            sum_d  = chk_sum;
                            idx_d  = idx_q + 8'd1;
                            if ((idx_q + 8'd1) == len_q) state_d = S_CHK;
                        end
                        default: begin // S_CHK
                            if (chk_sum != 8'd0) begin
                                frame_err_d = 1'b1;
                                err_code_d  = ERR_CHK;
                                state_d     = S_IDLE;
                            end else if (len_q == 8'd0) begin
                                frame_done_d = 1'b1;
                                state_d      = S_IDLE;
                            end else begin
                                // Launch the first write now so the burst
                                // starts the cycle after the CHK byte.
                                wr_en_d   = 1'b1;
                                wr_addr_d = base_q;
                                wr_data_d = pay_mem_q[0];
                                idx_d     = 8'd1;
                                state_d   = S_COMMIT;
                            end
                        end
                    endcase
`ifdef UART_FRAME_TIMEOUT_EN
                end else if (to_hit) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = S_IDLE;
`endif
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);

`ifdef UART_FRAME_TIMEOUT_EN
        // Counts idle cycles between bytes while a frame is being parsed.
        to_cnt_d = (parse_state && !rx_done && (state_d != S_IDLE)) ?
                   to_cnt_q + 16'd1 : 16'd0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= 8'd0;
            len_q        <= 8'd0;
            sum_q        <= 8'd0;
            idx_q        <= 8'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 8'd0;
            wr_data_q    <= 8'd0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            idx_q        <= idx_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            busy_q       <= busy_d;
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= 16'd0;
        else        to_cnt_q <= to_cnt_d;
    end
`endif

    // NOTE: the payload buffer has no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (pay_we) pay_mem_q[idx_q[IDX_W-1:0]] <= rx_data;
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign busy       = busy_q;

endmodule
